blur_frame_ctrl: RTL and testbench

Frame sequencer for the `gaussian_blur` 3x3 datapath. It accepts one frame of 8-bit pixels from an upstream valid/ready stream and feeds them into the blur core. It then injects padding pixels to flush the core's line buffers and forwards exactly one frame of blurred pixels downstream, flagging the frame's last pixel. It sits between the frame source (DMA/camera interface) and the blur core, and owns frame start, completion, abort and timeout.

---
 rtl/blur_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_blur_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blur_frame_ctrl.sv
// blur_frame_ctrl: sequences one frame through the 3x3 blur core, flushing its line
// buffers with padding and forwarding exactly IMG_W*IMG_H blurred pixels downstream.
module blur_frame_ctrl #(
  parameter int          IMG_W    = 64,
  parameter int          IMG_H    = 64,
  parameter logic [7:0]  PAD_VAL  = 8'h00,
  parameter int          DRAIN_TO = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_pixel,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] blur_pixel,
  output logic       blur_vld,
  input  logic [7:0] blur_out,
  input  logic       blur_vld_out,
  output logic [7:0] m_pixel,
  output logic       m_valid,
  output logic       m_last,
  output logic       busy,
  output logic       done,
  output logic       frame_err
);
  localparam int N         = IMG_W * IMG_H;
  localparam int FLUSH_LEN = IMG_W + 1;
  localparam int CW        = $clog2(IMG_W);
  localparam int RW        = $clog2(IMG_H);
  localparam int FW        = $clog2(FLUSH_LEN + 1);
  localparam int OW        = $clog2(N + 1);
  localparam int DW        = $clog2(DRAIN_TO + 1);
  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [FW-1:0] flush_q;
  logic [OW-1:0] out_cnt_q;
  logic [DW-1:0] drain_q;
  logic [7:0]    blur_pixel_q, m_pixel_q;
  logic          blur_vld_q, m_valid_q, m_last_q, done_q, frame_err_q;
  logic          hs, fwd, last_col, last_row;
  assign s_ready    = state_q == FEED;
  assign busy       = state_q != IDLE;
  assign blur_pixel = blur_pixel_q;
  assign blur_vld   = blur_vld_q;
  assign m_pixel    = m_pixel_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign done       = done_q;
  assign frame_err  = frame_err_q;
  assign hs         = s_valid && s_ready;
  assign last_col   = col_q == CW'(IMG_W - 1);
  assign last_row   = row_q == RW'(IMG_H - 1);
  // core outputs past the frame's N pixels, or while idle, are dropped
  assign fwd        = blur_vld_out && !abort && state_q != IDLE && out_cnt_q != OW'(N);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      flush_q      <= '0;
      out_cnt_q    <= '0;
      drain_q      <= '0;
      blur_pixel_q <= '0;
      blur_vld_q   <= 1'b0;
      m_pixel_q    <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      blur_vld_q <= 1'b0;
      m_valid_q  <= fwd;
      m_last_q   <= fwd && out_cnt_q == OW'(N - 1);
      if (fwd) begin
        m_pixel_q <= blur_out;
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (abort) state_q <= IDLE;
      else case (state_q)
        IDLE: if (start) begin
          state_q     <= FEED;
          col_q       <= '0;
          row_q       <= '0;
          flush_q     <= '0;
          out_cnt_q   <= '0;
          drain_q     <= '0;
          frame_err_q <= 1'b0;
        end
        FEED: if (hs) begin
          blur_pixel_q <= s_pixel;
          blur_vld_q   <= 1'b1;
          col_q        <= last_col ? '0 : col_q + 1'b1;
          if (last_col && last_row) state_q <= FLUSH;
          else if (last_col) row_q <= row_q + 1'b1;
        end
        FLUSH: begin
          blur_pixel_q <= PAD_VAL;
          blur_vld_q   <= 1'b1;
          if (flush_q == FW'(FLUSH_LEN - 1)) state_q <= DRAIN;
          else flush_q <= flush_q + 1'b1;
        end
        DRAIN: begin
          if (out_cnt_q == OW'(N)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (drain_q == DW'(DRAIN_TO - 1)) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            frame_err_q <= 1'b1;
          end else drain_q <= drain_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blur_frame_ctrl.sv
// tb_blur_frame_ctrl: directed scenarios for a 4x3 frame against a delay-5 blur core model.
module tb_blur_frame_ctrl;
  localparam logic [7:0] PAD = 8'hA5;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0;
  logic [7:0] s_pixel = 0;
  logic s_ready, blur_vld, blur_vld_out, m_valid, m_last, busy, done, frame_err;
  logic [7:0] blur_pixel, blur_out, m_pixel;
  int cmp = 0, err = 0, cyc = 0;
  int n_mv = 0, n_last = 0, n_bv = 0, n_pad = 0, n_done = 0;
  int last_cyc = 0, done_cyc = 0, pad_first = 0, pad_last = 0;
  logic [7:0] mpix [256];
  logic core_clr = 0;
  int core_max = 12, ck = 0, cn = 0;
  logic [7:0] hist [32];
  logic core_vld = 0;
  logic [7:0] core_pix = 0;

  blur_frame_ctrl #(.IMG_W(4), .IMG_H(3), .PAD_VAL(PAD), .DRAIN_TO(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_pixel(s_pixel),
    .s_valid(s_valid), .s_ready(s_ready), .blur_pixel(blur_pixel), .blur_vld(blur_vld),
    .blur_out(blur_out), .blur_vld_out(blur_vld_out), .m_pixel(m_pixel), .m_valid(m_valid),
    .m_last(m_last), .busy(busy), .done(done), .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // core stand-in: for its k-th input emits input k-5, registered, up to core_max outputs
  always @(posedge clk) begin
    if (core_clr) begin
      ck <= 0; cn <= 0; core_vld <= 1'b0;
    end else begin
      core_vld <= 1'b0;
      if (blur_vld) begin
        hist[ck % 32] <= blur_pixel;
        ck <= ck + 1;
        if (ck >= 5 && cn < core_max) begin
          core_vld <= 1'b1;
          core_pix <= hist[(ck - 5) % 32];
          cn <= cn + 1;
        end
      end
    end
  end
  assign blur_vld_out = core_vld;
  assign blur_out = core_pix;

  always @(negedge clk) if (!rst) begin
    if (m_valid) begin
      mpix[n_mv % 256] = m_pixel;
      n_mv++;
      if (m_last) begin n_last++; last_cyc = cyc; end
    end
    if (blur_vld) begin
      n_bv++;
      if (blur_pixel == PAD) begin
        if (n_pad == 0 || pad_last != cyc - 1) pad_first = cyc;
        pad_last = cyc;
        n_pad++;
      end
    end
    if (done) begin n_done++; done_cyc = cyc; end
  end

  task automatic do_start();
    start = 1; core_clr = 1;
    @(posedge clk); #1;
    start = 0; core_clr = 0;
  endtask

  task automatic feed(input bit toggle, input int abort_at, input bit mid_start);
    int idx = 0, g = 0;
    bit hs, st;
    while (idx < 12 && g < 100) begin
      s_valid = toggle ? (g % 2 == 0) : 1'b1;
      s_pixel = 8'h10 + idx[7:0];
      abort = (idx == abort_at) && s_valid;
      st = mid_start && idx == 3;
      start = st;
      @(negedge clk); hs = s_valid && s_ready;
      @(posedge clk); #1;
      abort = 0; start = 0;
      if (st) begin
        cmp++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin err++; $display("FAIL start_in_feed: busy=%b s_ready=%b want 1 1", busy, s_ready); end
      end
      if (hs) idx++;
      g++;
      if (abort_at >= 0 && idx > abort_at) break;
    end
    s_valid = 0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int g = 0;
    while (n_done == d0 && g < 200) begin @(posedge clk); #1; g++; end
    cmp++;
    if (n_done == d0) begin err++; $display("FAIL %s_done_timeout: done count %0d want %0d", nm, n_done - d0, 1); end
  endtask

  task automatic check_frame(input string nm, input int mv0, input int l0);
    int bad = 0;
    for (int i = 0; i < 12; i++) if (mpix[(mv0 + i) % 256] !== 8'h10 + i[7:0]) bad++;
    cmp++;
    if (n_mv - mv0 !== 12) begin err++; $display("FAIL %s_mvalid_count: got %0d want 12", nm, n_mv - mv0); end
    cmp++;
    if (bad !== 0) begin err++; $display("FAIL %s_pixel_order: %0d wrong pixels want 0", nm, bad); end
    cmp++;
    if (n_last - l0 !== 1) begin err++; $display("FAIL %s_mlast_count: got %0d want 1", nm, n_last - l0); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    cmp++;
    if ({s_ready, blur_pixel, blur_vld, m_pixel, m_valid, m_last, busy, done, frame_err} !== 24'd0) begin
      err++; $display("FAIL reset_values: got %h want 0", {s_ready, blur_pixel, blur_vld, m_pixel, m_valid, m_last, busy, done, frame_err});
    end
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int mv0 = n_mv, l0 = n_last, d0 = n_done, bv0 = n_bv, p0 = n_pad;
    do_start();
    cmp++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin err++; $display("FAIL normal_feed_entry: busy=%b s_ready=%b want 1 1", busy, s_ready); end
    feed(0, -1, 0);
    wait_done(d0, "normal");
    check_frame("normal", mv0, l0);
    cmp++;
    if (done_cyc !== last_cyc + 1) begin err++; $display("FAIL normal_done_after_last: done cyc %0d want %0d", done_cyc, last_cyc + 1); end
    cmp++;
    if (n_pad - p0 !== 5 || pad_last - pad_first !== 4) begin err++; $display("FAIL normal_pads: got %0d pads span %0d want 5 span 4", n_pad - p0, pad_last - pad_first); end
    cmp++;
    if (n_bv - bv0 !== 17) begin err++; $display("FAIL normal_blur_vld_count: got %0d want 17", n_bv - bv0); end
    cmp++;
    if (frame_err !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL normal_end_state: frame_err=%b busy=%b want 0 0", frame_err, busy); end
  endtask

  task automatic test_toggle();
    int mv0 = n_mv, l0 = n_last, d0 = n_done, bv0 = n_bv, p0 = n_pad;
    do_start();
    feed(1, -1, 0);
    wait_done(d0, "toggle");
    check_frame("toggle", mv0, l0);
    cmp++;
    if ((n_bv - bv0) - (n_pad - p0) !== 12) begin err++; $display("FAIL toggle_feed_pulses: got %0d want 12", (n_bv - bv0) - (n_pad - p0)); end
  endtask

  task automatic test_timeout();
    int mv0 = n_mv, l0 = n_last, d0 = n_done;
    core_max = 10;
    do_start();
    feed(0, -1, 0);
    wait_done(d0, "timeout");
    cmp++;
    if (n_mv - mv0 !== 10 || n_last - l0 !== 0) begin err++; $display("FAIL timeout_outputs: got %0d valid %0d last want 10 0", n_mv - mv0, n_last - l0); end
    cmp++;
    if (frame_err !== 1'b1) begin err++; $display("FAIL timeout_frame_err: got %b want 1", frame_err); end
    cmp++;
    if (done_cyc - pad_last !== 16) begin err++; $display("FAIL timeout_drain_len: got %0d want 16", done_cyc - pad_last); end
    core_max = 12;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if (frame_err !== 1'b1) begin err++; $display("FAIL timeout_err_held: got %b want 1", frame_err); end
    mv0 = n_mv; l0 = n_last; d0 = n_done;
    do_start();
    cmp++;
    if (frame_err !== 1'b0) begin err++; $display("FAIL timeout_err_cleared: got %b want 0", frame_err); end
    feed(0, -1, 0);
    wait_done(d0, "after_timeout");
    check_frame("after_timeout", mv0, l0);
  endtask

  task automatic test_abort();
    int mv0, l0, d0 = n_done;
    do_start();
    feed(0, 5, 0);
    cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || blur_vld !== 1'b0) begin err++; $display("FAIL abort_state: busy=%b s_ready=%b blur_vld=%b want 0 0 0", busy, s_ready, blur_vld); end
    repeat (30) @(posedge clk);
    #1;
    cmp++;
    if (n_done !== d0 || m_valid !== 1'b0) begin err++; $display("FAIL abort_no_done: done count %0d m_valid=%b want 0 0", n_done - d0, m_valid); end
    mv0 = n_mv; l0 = n_last; d0 = n_done;
    do_start();
    feed(0, -1, 0);
    wait_done(d0, "after_abort");
    check_frame("after_abort", mv0, l0);
  endtask

  task automatic test_ignored_start();
    int mv0 = n_mv, l0 = n_last, d0 = n_done;
    do_start();
    feed(0, -1, 1);
    wait_done(d0, "mid_start");
    check_frame("mid_start", mv0, l0);
    repeat (3) @(posedge clk);
    #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin err++; $display("FAIL start_with_abort: busy=%b s_ready=%b want 0 0", busy, s_ready); end
  endtask

  task automatic test_reset_mid_flush();
    int mv0, l0, d0;
    do_start();
    feed(0, -1, 0);
    repeat (2) @(posedge clk);
    #3;
    cmp++;
    if (blur_pixel !== PAD || blur_vld !== 1'b1) begin err++; $display("FAIL mid_flush_reached: blur_pixel=%h blur_vld=%b want %h 1", blur_pixel, blur_vld, PAD); end
    rst = 1;
    #1;
    cmp++;
    if ({s_ready, blur_pixel, blur_vld, m_pixel, m_valid, m_last, busy, done, frame_err} !== 24'd0) begin
      err++; $display("FAIL async_reset: got %h want 0", {s_ready, blur_pixel, blur_vld, m_pixel, m_valid, m_last, busy, done, frame_err});
    end
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    mv0 = n_mv; l0 = n_last; d0 = n_done;
    do_start();
    feed(0, -1, 0);
    wait_done(d0, "after_reset");
    check_frame("after_reset", mv0, l0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_toggle();
    test_timeout();
    test_abort();
    test_ignored_start();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
